spi_master_ctrl: RTL and testbench
==================================

Name: spi_master_ctrl

Overview:
- Single-byte SPI master controller (mode 0: CPOL=0, CPHA=0, LSB-first) that sequences the team's 8-bit right-shifting shift register datapath.
- Accepts a byte on a start/ready handshake, generates SCLK, CS_n and MOSI, samples MISO, and returns the received byte with a one-cycle done pulse.
- Sits between the register/bus front end and the SPI pads.

Parameters:
- DATA_W, 8, bits per transfer (>=2).
- CLK_DIV, 2, clk cycles per SCLK half-period (>=1).

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-low reset.
- start  in  1  transfer request; accepted only when ready=1.
- tx_data  in  DATA_W  byte to send; sampled in the accept cycle.
- ready  out  1  high only in IDLE.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse; rx_data is valid from this cycle.
- rx_data  out  DATA_W  last received byte; holds until the next done.
- sclk  out  1  SPI clock, idle low.
- mosi  out  1  serial out, equal to shift_data[0].
- miso  in  1  serial in.
- cs_n  out  1  chip select, active low.

Behaviour:
- Reset (rst=0 at a posedge):
  - Next state IDLE; outputs cs_n=1, sclk=0, done=0, ready=1, busy=0, rx_data=0.
  - Internal shift_data, bit counter and divider counter cleared.
  - Applies mid-transfer: the transfer is aborted with no done pulse.
- States and transitions:
  - IDLE: on start=1, latch tx_data and go to LOAD.
  - LOAD: shift_data<=latched byte; cs_n<=0; go to SETUP.
  - SETUP: hold CLK_DIV cycles with sclk=0 and mosi=bit0; go to XFER.
  - XFER: sclk toggles every CLK_DIV cycles.
    - Rising edge: sample miso into samp_bit.
    - Falling edge: shift_data<={samp_bit, shift_data[DATA_W-1:1]} and bit_cnt++.
    - After the DATA_W-th falling edge go to HOLD; sclk ends low.
  - HOLD: cs_n stays low for CLK_DIV cycles; go to DONE.
  - DONE: rx_data<=shift_data; done=1; cs_n<=1; go to IDLE on the next cycle.
- Latency:
  - Start accepted at cycle 0; done asserts at cycle 2+CLK_DIV*(2*DATA_W+2).
  - With defaults this is cycle 38.
  - cs_n is low from cycle 2 through the DONE cycle (it deasserts on the following edge).
- Handshake and boundary rules:
  - start while busy is ignored and tx_data is not re-sampled.
  - start during the DONE cycle is ignored (ready=0); back-to-back transfers are separated by at least one IDLE cycle.
  - mosi changes only on SCLK falling edges or in LOAD, never coincident with a rising edge.
  - bit_cnt width is clog2(DATA_W+1) and it never wraps within a transfer.

Optional Feature:
- Macro: SPI_LOOPBACK_EN.
- Defined: the internal sample source is mosi instead of miso, so rx_data equals tx_data for every transfer; the miso pin is ignored.
- Undefined: samples come from miso as specified above.
- Pin behaviour (sclk/cs_n/mosi) is identical in both cases.

Decomposition:
- Package spi_pkg:
  - state enum {IDLE, LOAD, SETUP, XFER, HOLD, DONE}.
  - Default DATA_W/CLK_DIV constants.
  - SPI mode localparams.
- Sub-module spi_clk_div:
  - Counter 0..CLK_DIV-1 with synchronous enable and clear.
  - Emits a one-cycle half_tick pulse; used in SETUP, XFER and HOLD.

Test Plan:
- Defaults, tx_data=0xA5, miso driven by a slave model returning 0x3C LSB-first -> mosi bits 1,0,1,0,0,1,0,1 on rising edges; rx_data=0x3C; done at cycle 38; exactly 8 sclk rising edges.
- SPI_LOOPBACK_EN defined, tx_data=0x5A, miso tied to 0 -> rx_data=0x5A.
- Second start=1 with tx_data=0xFF at cycle 10 of a 0x01 transfer -> ignored; mosi stream stays 0x01; a single done pulse.
- rst=0 at cycle 20 of a transfer -> next cycle cs_n=1, sclk=0, ready=1, rx_data=0x00, no done pulse; a new start then completes normally.
- CLK_DIV=1, DATA_W=8 -> sclk period 2 clk cycles; done at cycle 20; cs_n low for cycles 2-20.
- start held high continuously -> transfers repeat with done pulses 39 cycles apart and ready=1 for one cycle between them.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types and constants for the single-byte SPI master (mode 0, LSB-first).
// Optional build macro SPI_LOOPBACK_EN is consumed by spi_master_ctrl.
package spi_pkg;

   localparam int DEFAULT_DATA_W  = 8;
   localparam int DEFAULT_CLK_DIV = 2;

   // {CPOL, CPHA}; mode 0 idles sclk low and samples on the leading edge.
   localparam logic [1:0] SPI_MODE = 2'd0;
   localparam logic       SPI_CPOL = SPI_MODE[1];
   localparam logic       SPI_CPHA = SPI_MODE[0];

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      SETUP,
      XFER,
      HOLD,
      DONE
   } state_t;

   // Cycles from the accept cycle to the done cycle.
   function automatic int transfer_latency(input int data_w, input int clk_div);
      return 2 + clk_div * (2 * data_w + 2);
   endfunction

endpackage

// File: rtl/spi_clk_div.sv
// Half-period divider: counts 0..CLK_DIV-1 while enabled and pulses half_tick on
// the last count. Clear has priority over enable.
module spi_clk_div #(
   parameter int CLK_DIV = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic clr,
   output logic half_tick
);

   localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   logic [CNT_W-1:0] cnt;
   logic             at_end;

   assign at_end    = (cnt == CNT_W'(CLK_DIV - 1));
   assign half_tick = en && at_end;

   // NOTE: clocked state uses non-blocking (<=) so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= at_end ? '0 : cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/spi_master_ctrl.sv
// Single-transfer SPI master (mode 0, LSB-first) sequencing a right-shifting datapath.
// Define SPI_LOOPBACK_EN to sample mosi instead of miso (rx_data == tx_data).
module spi_master_ctrl
   import spi_pkg::*;
#(
   parameter int DATA_W  = DEFAULT_DATA_W,
   parameter int CLK_DIV = DEFAULT_CLK_DIV
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [DATA_W-1:0] tx_data,
   output logic              ready,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] rx_data,
   output logic              sclk,
   output logic              mosi,
   input  logic              miso,
   output logic              cs_n
);

   localparam int               CNT_W    = $clog2(DATA_W + 1);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

   state_t            state;
   state_t            next_state;
   logic [DATA_W-1:0] tx_latch;
   logic [DATA_W-1:0] shift_data;
   logic [CNT_W-1:0]  bit_cnt;
   logic              samp_bit;
   logic              samp_src;
   logic              div_run;
   logic              half_tick;
   logic              accept;
   logic              load;
   logic              sample_edge;
   logic              shift_edge;
   logic              capture;
   logic              release_cs;

`ifdef SPI_LOOPBACK_EN
   logic unused_miso;
   assign unused_miso = miso;
   assign samp_src    = mosi;
`else
   assign samp_src    = miso;
`endif

   assign ready   = (state == IDLE);
   assign busy    = (state != IDLE);
   assign done    = (state == DONE);
   assign mosi    = shift_data[0];
   assign div_run = (state == SETUP) || (state == XFER) || (state == HOLD);

   spi_clk_div #(
      .CLK_DIV (CLK_DIV)
   ) u_clk_div (
      .clk       (clk),
      .rst       (rst),
      .en        (div_run),
      .clr       (!div_run),
      .half_tick (half_tick)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      next_state  = state;
      accept      = 1'b0;
      load        = 1'b0;
      sample_edge = 1'b0;
      shift_edge  = 1'b0;
      capture     = 1'b0;
      release_cs  = 1'b0;
      unique case (state)
         IDLE: begin
            if (start) begin
               accept     = 1'b1;
               next_state = LOAD;
            end
         end
         LOAD: begin
            load       = 1'b1;
            next_state = SETUP;
         end
         SETUP: begin
            if (half_tick) next_state = XFER;
         end
         XFER: begin
            // The leading sclk edge samples; the trailing edge shifts and advances mosi.
            if (half_tick) begin
               if (sclk == (SPI_CPOL ^ SPI_CPHA)) begin
                  sample_edge = 1'b1;
               end else begin
                  shift_edge = 1'b1;
                  if (bit_cnt == LAST_BIT) next_state = HOLD;
               end
            end
         end
         HOLD: begin
            if (half_tick) begin
               capture    = 1'b1;
               next_state = DONE;
            end
         end
         DONE: begin
            release_cs = 1'b1;
            next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         tx_latch   <= '0;
         shift_data <= '0;
         bit_cnt    <= '0;
         samp_bit   <= 1'b0;
         sclk       <= SPI_CPOL;
         cs_n       <= 1'b1;
         rx_data    <= '0;
      end else begin
         if (accept) tx_latch <= tx_data;
         if (load) begin
            shift_data <= tx_latch;
            bit_cnt    <= '0;
            sclk       <= SPI_CPOL;
            cs_n       <= 1'b0;
         end
         if (sample_edge) begin
            sclk     <= ~sclk;
            samp_bit <= samp_src;
         end
         if (shift_edge) begin
            sclk       <= ~sclk;
            shift_data <= {samp_bit, shift_data[DATA_W-1:1]};
            bit_cnt    <= bit_cnt + CNT_W'(1);
         end
         // Captured on entry to DONE so rx_data is already valid while done is high.
         if (capture)    rx_data <= shift_data;
         if (release_cs) cs_n    <= 1'b1;
      end
   end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Self-checking bench: a default instance (CLK_DIV=2) with a mode-0 slave model and a
// CLK_DIV=1 instance; expected transfers go through scoreboard queues.
module tb_spi_master_ctrl;

   localparam bit LOOPBACK =
`ifdef SPI_LOOPBACK_EN
      1'b1;
`else
      1'b0;
`endif

   typedef struct packed {
      logic [7:0] tx;
      logic [7:0] rx;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       start0, start1;
   logic [7:0] tx0, tx1;
   logic       ready0, busy0, done0, sclk0, mosi0, miso0, cs_n0;
   logic       ready1, busy1, done1, sclk1, mosi1, miso1, cs_n1;
   logic [7:0] rx0, rx1;

   exp_t q0[$];
   exp_t q1[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   cyc      = 0;

   logic [7:0] slave0 = 8'h00;
   int   sidx0 = 0;
   int   acc0 = 0, rise0 = 0, first_rise0 = 0, last_rise0 = 0, dones0 = 0;
   int   last_done0 = -1, ready_run0 = 0;
   logic [7:0] mosi_w0 = 8'h00;
   logic prev_sclk0 = 1'b0, prev_cs0 = 1'b1;
   bit   gap_mode = 1'b0;

   int   acc1 = 0, rise1 = 0, first_rise1 = 0, last_rise1 = 0, cs_low1 = 0, dones1 = 0;
   logic prev_sclk1 = 1'b0, prev_cs1 = 1'b1;

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   // miso1 is tied off; a nonzero constant makes a stuck-at-reset rx_data visible.
   assign miso1 = LOOPBACK ? 1'b0 : 1'b1;

   spi_master_ctrl #(.DATA_W(8), .CLK_DIV(2)) u_dut0 (
      .clk(clk), .rst(rst), .start(start0), .tx_data(tx0), .ready(ready0), .busy(busy0),
      .done(done0), .rx_data(rx0), .sclk(sclk0), .mosi(mosi0), .miso(miso0), .cs_n(cs_n0)
   );

   spi_master_ctrl #(.DATA_W(8), .CLK_DIV(1)) u_dut1 (
      .clk(clk), .rst(rst), .start(start1), .tx_data(tx1), .ready(ready1), .busy(busy1),
      .done(done1), .rx_data(rx1), .sclk(sclk1), .mosi(mosi1), .miso(miso1), .cs_n(cs_n1)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic wait_done(input int which, input int budget, input string tag);
      bit seen = 1'b0;
      for (int k = 0; k < budget && !seen; k++) begin
         @(negedge clk);
         #1;
         seen = (which == 0) ? done0 : done1;
      end
      check(tag, seen, 1);
      tick(1);
   endtask

   // Monitor and mode-0 slave for instance 0 (samples at negedge, away from posedge).
   always @(negedge clk) begin
      exp_t e;
      if (!gap_mode) last_done0 = -1;
      if (ready0 && start0) acc0 = cyc;
      if (prev_cs0 && !cs_n0) begin
         rise0   = 0;
         mosi_w0 = 8'h00;
         sidx0   = 0;
      end
      if (sclk0 && !prev_sclk0) begin
         if (rise0 == 0) first_rise0 = cyc;
         last_rise0 = cyc;
         if (rise0 < 8) mosi_w0[rise0] = mosi0;
         rise0++;
      end
      if (!sclk0 && prev_sclk0) sidx0++;
      miso0 = (sidx0 < 8) ? slave0[sidx0] : 1'b0;
      if (ready0) ready_run0++;
      if (done0) begin
         dones0++;
         check("d0_sb_entry", q0.size() != 0, 1);
         if (q0.size() != 0) begin
            e = q0.pop_front();
            check("d0_rx_data", rx0, e.rx);
            check("d0_mosi_stream", mosi_w0, e.tx);
            check("d0_latency", cyc - acc0, 38);
            check("d0_sclk_rises", rise0, 8);
            check("d0_rise_span", last_rise0 - first_rise0, 28);
            if (gap_mode && last_done0 >= 0) begin
               check("d0_done_gap", cyc - last_done0, 39);
               check("d0_ready_between", ready_run0, 1);
            end
         end
         last_done0 = cyc;
         ready_run0 = 0;
      end
      prev_sclk0 = sclk0;
      prev_cs0   = cs_n0;
   end

   always @(negedge clk) begin
      exp_t e;
      if (ready1 && start1) begin
         acc1    = cyc;
         cs_low1 = 0;
      end
      if (!cs_n1) cs_low1++;
      if (prev_cs1 && !cs_n1) rise1 = 0;
      if (sclk1 && !prev_sclk1) begin
         if (rise1 == 0) first_rise1 = cyc;
         last_rise1 = cyc;
         rise1++;
      end
      if (done1) begin
         dones1++;
         check("d1_sb_entry", q1.size() != 0, 1);
         if (q1.size() != 0) begin
            e = q1.pop_front();
            check("d1_rx_data", rx1, e.rx);
            check("d1_latency", cyc - acc1, 20);
            check("d1_cs_low_cycles", cs_low1, 19);
            check("d1_sclk_rises", rise1, 8);
            check("d1_rise_span", last_rise1 - first_rise1, 14);
         end
      end
      prev_sclk1 = sclk1;
      prev_cs1   = cs_n1;
   end

   initial begin
      #100000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int d;
      int seen_n;
      rst = 1'b0; start0 = 1'b0; start1 = 1'b0; tx0 = 8'h00; tx1 = 8'h00;
      tick(3);
      check("rst_cs_n0", cs_n0, 1);
      check("rst_sclk0", sclk0, 0);
      check("rst_done0", done0, 0);
      check("rst_ready0", ready0, 1);
      check("rst_busy0", busy0, 0);
      check("rst_rx0", rx0, 0);
      check("rst_cs_n1", cs_n1, 1);
      check("rst_ready1", ready1, 1);
      rst = 1'b1;
      tick(1);

      // A5 out, slave returns 3C
      slave0 = 8'h3C;
      q0.push_back('{tx: 8'hA5, rx: LOOPBACK ? 8'hA5 : 8'h3C});
      tx0 = 8'hA5; start0 = 1'b1;
      tick(1);
      start0 = 1'b0; tx0 = 8'h00;
      tick(4);
      check("a_busy_mid", busy0, 1);
      check("a_ready_mid", ready0, 0);
      check("a_cs_n_mid", cs_n0, 0);
      wait_done(0, 60, "a_done_seen");
      check("a_cs_n_after", cs_n0, 1);
      tick(3);
      check("a_rx_hold", rx0, LOOPBACK ? 8'hA5 : 8'h3C);

      // 01 out; start with FF at cycle 10 must be ignored
      slave0 = 8'h96;
      d = dones0;
      q0.push_back('{tx: 8'h01, rx: LOOPBACK ? 8'h01 : 8'h96});
      tx0 = 8'h01; start0 = 1'b1;
      tick(1);
      start0 = 1'b0; tx0 = 8'h00;
      tick(9);
      tx0 = 8'hFF; start0 = 1'b1;
      tick(1);
      start0 = 1'b0; tx0 = 8'h00;
      wait_done(0, 60, "b_done_seen");
      tick(45);
      check("b_single_done", dones0 - d, 1);

      // reset at cycle 20 aborts the transfer without a done pulse
      slave0 = 8'h55;
      d = dones0;
      tx0 = 8'h77; start0 = 1'b1;
      tick(1);
      start0 = 1'b0; tx0 = 8'h00;
      tick(19);
      rst = 1'b0;
      tick(1);
      check("c_cs_n", cs_n0, 1);
      check("c_sclk", sclk0, 0);
      check("c_ready", ready0, 1);
      check("c_busy", busy0, 0);
      check("c_rx_cleared", rx0, 0);
      rst = 1'b1;
      tick(50);
      check("c_no_done", dones0 - d, 0);
      slave0 = 8'h81;
      q0.push_back('{tx: 8'hC3, rx: LOOPBACK ? 8'hC3 : 8'h81});
      tx0 = 8'hC3; start0 = 1'b1;
      tick(1);
      start0 = 1'b0; tx0 = 8'h00;
      wait_done(0, 60, "c_restart_done_seen");

      // start held high: back-to-back transfers 39 cycles apart
      slave0 = 8'hE7;
      gap_mode = 1'b1;
      d = dones0;
      repeat (3) q0.push_back('{tx: 8'h3A, rx: LOOPBACK ? 8'h3A : 8'hE7});
      tx0 = 8'h3A; start0 = 1'b1;
      seen_n = 0;
      for (int k = 0; k < 200 && seen_n < 3; k++) begin
         @(negedge clk);
         #1;
         if (done0) seen_n++;
      end
      start0 = 1'b0; tx0 = 8'h00;
      check("d_done_count", seen_n, 3);
      tick(45);
      gap_mode = 1'b0;
      check("d_total_dones", dones0 - d, 3);
      check("d_ready_idle", ready0, 1);

      // CLK_DIV=1 instance, 5A out
      q1.push_back('{tx: 8'h5A, rx: LOOPBACK ? 8'h5A : 8'hFF});
      tx1 = 8'h5A; start1 = 1'b1;
      tick(1);
      start1 = 1'b0; tx1 = 8'h00;
      wait_done(1, 40, "e_done_seen");
      check("e_cs_n_after", cs_n1, 1);
      check("e_ready_after", ready1, 1);
      check("e_single_done", dones1, 1);

      check("q0_drained", q0.size(), 0);
      check("q1_drained", q1.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
